// File: rtl/shift_unit_pkg.sv
// Shared definitions for the sequential shift unit: operation codes and FSM state encoding.
package shift_unit_pkg;

  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;
  localparam logic [2:0] SH_SRA  = 3'b100;
  localparam logic [2:0] SH_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_unit_if.sv
// Request/result bus of the shift unit; master drives the request, slave returns the result.
interface shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_out;
  logic               busy;
  logic               done;

  modport master (
    output start, op, data_in, shamt,
    input  data_out, busy, done
  );

  modport slave (
    input  start, op, data_in, shamt,
    output data_out, busy, done
  );
endinterface

// File: rtl/shift_unit_step.sv
// Combinational single-bit shift step. Rotate-right is decoded only when SHIFT_ROTATE_EN is defined;
// otherwise 3'b101 falls through to the pass-through (load) case.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             is_shift
);

  // One-bit step per opcode; is_shift flags opcodes that actually iterate.
  always_comb begin
    next_value = value;
    is_shift   = 1'b0;
    case (op)
      SH_SLL: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        is_shift   = 1'b1;
      end
      SH_SRL: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        is_shift   = 1'b1;
      end
      SH_SRA: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        is_shift   = 1'b1;
      end
`ifdef SHIFT_ROTATE_EN
      SH_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        is_shift   = 1'b1;
      end
`else
`endif
      default: begin
        next_value = value;
        is_shift   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Sequential shift unit: loads an operand and shifts it one bit per clock under start/busy/done.
// Optional rotate-right support is enabled by defining SHIFT_ROTATE_EN.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  shift_unit_if.slave   bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2:0]         step_op_s;
  logic [WIDTH-1:0]   step_value_s;
  logic               step_is_shift_s;

  // In IDLE the step unit decodes the incoming opcode; afterwards it works on the latched one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      step_op_s = bus.op;
    end else begin
      step_op_s = op_q;
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op         (step_op_s),
    .value      (data_q),
    .next_value (step_value_s),
    .is_shift   (step_is_shift_s)
  );

  // Next-state, counter and working-register logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          data_d = bus.data_in;
          op_d   = bus.op;
          if (!step_is_shift_s || (bus.shamt == {SHAMT_W{1'b0}})) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = bus.shamt;
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d = step_value_s;
        cnt_d  = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= {WIDTH{1'b0}};
      cnt_q   <= {SHAMT_W{1'b0}};
      op_q    <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: expected result and latency are queued at each start and
// compared when done rises.
module tb_shift_unit;
  import shift_unit_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) io();

  shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it until done; the expectation goes through the scoreboard.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] din,
                       input logic [4:0] sh, input logic [31:0] exp_data, input int exp_lat,
                       input bit pulse_mid);
    exp_t e;
    int   cycle;
    bit   seen;
    e.data = exp_data;
    e.lat  = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    io.start = 1'b1; io.op = op; io.data_in = din; io.shamt = sh;
    @(negedge clk);
    io.start = 1'b0; io.op = 3'($urandom_range(7, 0)); io.data_in = $urandom; io.shamt = 5'($urandom_range(31, 0));
    cycle = 1;
    seen  = 1'b0;
    while (!seen && cycle <= 40) begin
      chk({tag, "_busy"}, {31'd0, io.busy}, 32'd1);
      if (io.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (pulse_mid && cycle == 2) begin
          io.start = 1'b1; io.op = SH_LOAD; io.data_in = 32'hDEAD_BEEF; io.shamt = 5'd0;
        end else begin
          io.start = 1'b0;
        end
        @(negedge clk);
        cycle++;
      end
    end
    io.start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(cycle), 32'(e.lat));
      chk({tag, "_data"}, io.data_out, e.data);
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, io.done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, io.busy}, 32'd0);
    chk({tag, "_hold"}, io.data_out, exp_data);
    if (pulse_mid) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk({tag, "_no_second_done"}, {30'd0, io.busy, io.done}, 32'd0);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    io.start = 1'b0; io.op = SH_LOAD; io.data_in = 32'hFFFF_FFFF; io.shamt = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_data", io.data_out, 32'h0);
    chk("reset_flags", {30'd0, io.busy, io.done}, 32'd0);
    rst_n = 1'b1;

    // Idle with no start: nothing moves.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_data", io.data_out, 32'h0);
      chk("idle_flags", {30'd0, io.busy, io.done}, 32'd0);
    end

    do_op("sll4",   SH_SLL,  32'h0000_0001, 5'd4,  32'h0000_0010, 5,  1'b0);
    do_op("sra31",  SH_SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32, 1'b0);
    do_op("srl31",  SH_SRL,  32'h8000_0000, 5'd31, 32'h0000_0001, 32, 1'b0);
    do_op("sra2",   SH_SRA,  32'h4000_0000, 5'd2,  32'h1000_0000, 3,  1'b0);
    do_op("sll0",   SH_SLL,  32'h1234_ABCD, 5'd0,  32'h1234_ABCD, 1,  1'b0);
    do_op("srl4pm", SH_SRL,  32'h0000_0100, 5'd4,  32'h0000_0010, 5,  1'b1);
    do_op("badop",  3'b111,  32'hCAFE_F00D, 5'd9,  32'hCAFE_F00D, 1,  1'b0);

    // Reset mid-operation: aborted, no done.
    @(negedge clk);
    io.start = 1'b1; io.op = SH_SRL; io.data_in = 32'hF000_0000; io.shamt = 5'd8;
    @(negedge clk);
    io.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_data", io.data_out, 32'h0);
    chk("abort_flags", {30'd0, io.busy, io.done}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_hold_flags", {30'd0, io.busy, io.done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_after_flags", {30'd0, io.busy, io.done}, 32'd0);
    chk("abort_after_data", io.data_out, 32'h0);
    do_op("load5",  SH_LOAD, 32'h0000_0005, 5'd3,  32'h0000_0005, 1,  1'b0);

`ifdef SHIFT_ROTATE_EN
    do_op("ror1",   SH_ROR,  32'h0000_0001, 5'd1,  32'h8000_0000, 2,  1'b0);
    do_op("ror4",   SH_ROR,  32'h0000_00A5, 5'd4,  32'h5000_000A, 5,  1'b0);
`else
    do_op("ror1",   SH_ROR,  32'h0000_0001, 5'd1,  32'h0000_0001, 1,  1'b0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
